bus_mem_responder: RTL
======================

# bus_mem_responder

Memory-side end of the core's request/response bus. Accepts read and write requests issued by the arbiter on behalf of the instruction and data caches, stores data in an internal word array, and returns read data as a multi-beat line burst with the request tag echoed. It is the bench and simulation target that the core's bus master talks to.

## Interface
- BUS_DATA_WIDTH, 64, width of request/response data and address beats
- BUS_TAG_WIDTH, 13, width of request/response tag
- BEATS, 4, 64-bit beats per line (power of two)
- DEPTH, 1024, words in backing array (power of two)
- LATENCY, 4, idle cycles between read accept and first response beat (0..255)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low
- bus_reqcyc  in  1  request/write-data beat valid
- bus_req  in  BUS_DATA_WIDTH  byte address (header beat) or write data (data beats)
- bus_reqtag  in  BUS_TAG_WIDTH  tag; bit 12 = 1 write, 0 read; bits 11:0 opaque
- bus_reqack  out  1  request beat accepted this cycle
- bus_respcyc  out  1  response beat valid
- bus_resp  out  BUS_DATA_WIDTH  read data beat
- bus_resptag  out  BUS_TAG_WIDTH  tag of the read being answered
- bus_respack  in  1  response beat consumed this cycle
- busy  out  1  state is not IDLE

## Operation
- States: IDLE, WDATA, WAIT, RESP.
- bus_reqack = bus_reqcyc & (state == IDLE | state == WDATA); combinational. A beat is consumed on any edge where bus_reqack is high.
- Word index = bus_req[3 +: log2(DEPTH)] (address modulo array size; bits 2:0 ignored). Line base = word index with low log2(BEATS) bits cleared.
- IDLE, accepted header, tag[12]=1: latch line base and tag, beat counter := 0, go WDATA.
- WDATA: each accepted beat writes bus_req to word (base + counter); counter increments; after beat BEATS-1 go IDLE. Writes are posted: no response issued.
- IDLE, accepted header, tag[12]=0: latch base, start word, tag; latency counter := LATENCY; go WAIT (LATENCY=0: go RESP directly).
- WAIT: decrement each cycle; at 1 go RESP.
- RESP: bus_respcyc=1, bus_resp = word(base + beat offset), bus_resptag = latched tag. Beat advances only on edge with bus_respack=1; output holds stable otherwise. After beat BEATS-1 acked go IDLE.
- bus_reqcyc in WAIT/RESP: ignored, bus_reqack=0; master must hold it.
- Beat offset arithmetic modulo BEATS (wrap within line, never crosses into adjacent line).

## Timing
- Reset values: bus_respcyc=0, bus_resp=0, bus_resptag=0, busy=0, state IDLE, counters 0. bus_reqack=0 while reset low.
- Reset mid-burst: abandon immediately; words already written stay written; array contents never cleared by reset.
- Read header accepted at edge T: first bus_respcyc high in cycle T+1+LATENCY; with respack held high, BEATS consecutive beats, IDLE at edge T+1+LATENCY+BEATS-1, next header accepted that same cycle.
- Write header at edge T: data beats accepted on next BEATS cycles with bus_reqcyc high; gaps (reqcyc low) stall without timeout.
- Read data sampled from array at beat presentation; a write cannot overlap a read burst.

## Configuration
- BUS_RESP_CRITICAL_WORD_FIRST_EN defined: read burst begins at requested word (word index low log2(BEATS) bits) and wraps modulo BEATS, e.g. word 2 of 4 returns 2,3,0,1.
- Undefined: read burst always starts at line base, order 0..BEATS-1; requested word bits ignored.
- Writes always start at line base in both builds.

## Test plan
- Reset: assert reset low mid-RESP -> respcyc=0, busy=0 same cycle; prior written data still readable afterwards.
- Write then read: write line at 0x40 with 0x11,0x22,0x33,0x44, tag 0x1005; read 0x40 tag 0x0005 -> respcyc first high 5 cycles after accept (LATENCY=4), beats 0x11,0x22,0x33,0x44, resptag 0x0005.
- Backpressure: same read, respack low 3 cycles on beat 1 -> bus_resp held at 0x22, no beat skipped or repeated.
- Critical word: read 0x50 -> macro defined 0x33,0x44,0x11,0x22; undefined 0x11,0x22,0x33,0x44.
- Busy rejection: reqcyc held during RESP -> reqack=0 until IDLE, then accepted first cycle of IDLE.
- Address wrap: write to byte address DEPTH*8+0x40 -> read of 0x40 returns that data.

Source files
------------

// File: rtl/bus_mem_responder.sv
// Memory-side responder for the core request/response bus: posted line writes, latency-delayed line-burst reads.
// Optional build macro BUS_RESP_CRITICAL_WORD_FIRST_EN: read bursts start at the requested word and wrap within the line.
module bus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BEATS          = 4,
  parameter int DEPTH          = 1024,
  parameter int LATENCY        = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack,
  output logic                      busy
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int BEAT_W = $clog2(BEATS);
  localparam int LINE_W = IDX_W - BEAT_W;

  typedef enum logic [1:0] {S_IDLE, S_WDATA, S_WAIT, S_RESP} state_t;

  state_t                    r_state, w_next;
  logic [LINE_W-1:0]         r_line;
  logic [BEAT_W-1:0]         r_nbeat;
  logic [BEAT_W-1:0]         r_off;
  logic [7:0]                r_lat;
  logic [BUS_TAG_WIDTH-1:0]  r_tag;
  logic [BUS_DATA_WIDTH-1:0] r_mem [DEPTH];

  logic              w_last;
  logic              w_wr;
  logic [BEAT_W-1:0] w_start;
  logic [IDX_W-1:0]  w_idx;

  assign bus_reqack = reset & bus_reqcyc & ((r_state == S_IDLE) | (r_state == S_WDATA));
  assign w_last     = (r_nbeat == BEAT_W'(BEATS - 1));
  assign w_wr       = (r_state == S_WDATA) & bus_reqack;
  // Writes walk the line with the beat count; reads use a separate offset that may start mid-line.
  assign w_idx      = {r_line, (r_state == S_RESP) ? r_off : r_nbeat};

`ifdef BUS_RESP_CRITICAL_WORD_FIRST_EN
  assign w_start = bus_req[3 +: BEAT_W];
`else
  assign w_start = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus_reqack) begin
                 if (bus_reqtag[BUS_TAG_WIDTH-1]) w_next = S_WDATA;
                 else if (LATENCY == 0)           w_next = S_RESP;
                 else                             w_next = S_WAIT;
               end
      S_WDATA: if (bus_reqack && w_last) w_next = S_IDLE;
      S_WAIT:  if (r_lat <= 8'd1) w_next = S_RESP;
      S_RESP:  if (bus_respack && w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state != S_IDLE);
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    bus_resptag = '0;
    if (r_state == S_RESP) begin
      bus_respcyc = 1'b1;
      bus_resp    = r_mem[w_idx];
      bus_resptag = r_tag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_line  <= '0;
      r_nbeat <= '0;
      r_off   <= '0;
      r_lat   <= '0;
      r_tag   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE:  if (bus_reqack) begin
                   r_line  <= bus_req[3 + BEAT_W +: LINE_W];
                   r_tag   <= bus_reqtag;
                   r_nbeat <= '0;
                   r_off   <= w_start;
                   r_lat   <= 8'(LATENCY);
                 end
        S_WDATA: if (bus_reqack) r_nbeat <= r_nbeat + 1'b1;
        S_WAIT:  r_lat <= r_lat - 8'd1;
        S_RESP:  if (bus_respack) begin
                   r_nbeat <= r_nbeat + 1'b1;
                   r_off   <= r_off + 1'b1;
                 end
        default: ;
      endcase
    end
  end

  // Backing store is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[w_idx] <= bus_req;
  end

endmodule
